// File: rtl/victim_cache_pkg.sv
// Shared types and default geometry for the victim cache slice.
package victim_cache_pkg;

  localparam int VC_LINE_W = 128;
  localparam int VC_TAG_W  = 26;
  localparam int VC_DEPTH  = 4;

  typedef enum logic {
    IDLE,
    EVICT
  } vc_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_LINE_W-1:0] data;
  } vc_entry_t;

endpackage

// File: rtl/victim_cache_if.sv
// L1-facing probe/insert ports, memory write-back port and perf counters.
interface victim_cache_if import victim_cache_pkg::*; #(
  parameter int LINE_W = VC_LINE_W,
  parameter int TAG_W  = VC_TAG_W
);
  logic              lookup_req;
  logic              lookup_ready;
  logic [TAG_W-1:0]  lookup_tag;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [LINE_W-1:0] rsp_data;
  logic              rsp_dirty;
  logic              insert_req;
  logic              insert_ready;
  logic [TAG_W-1:0]  insert_tag;
  logic [LINE_W-1:0] insert_data;
  logic              insert_dirty;
  logic              wb_req;
  logic [TAG_W-1:0]  wb_tag;
  logic [LINE_W-1:0] wb_data;
  logic              wb_ack;
  logic [31:0]       perf_hit_cnt;
  logic [31:0]       perf_miss_cnt;

  modport slave (
    input  lookup_req, lookup_tag, insert_req, insert_tag, insert_data, insert_dirty, wb_ack,
    output lookup_ready, rsp_valid, rsp_hit, rsp_data, rsp_dirty, insert_ready,
           wb_req, wb_tag, wb_data, perf_hit_cnt, perf_miss_cnt
  );

  modport master (
    output lookup_req, lookup_tag, insert_req, insert_tag, insert_data, insert_dirty, wb_ack,
    input  lookup_ready, rsp_valid, rsp_hit, rsp_data, rsp_dirty, insert_ready,
           wb_req, wb_tag, wb_data, perf_hit_cnt, perf_miss_cnt
  );
endinterface

// File: rtl/victim_cache_match.sv
// Combinational valid-qualified tag match plus lowest-index free-entry finder.
module victim_cache_match import victim_cache_pkg::*; #(
  parameter int TAG_W = VC_TAG_W,
  parameter int DEPTH = VC_DEPTH
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [TAG_W-1:0]         tags [DEPTH],
  input  logic [TAG_W-1:0]         key,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic                     free_found,
  output logic [$clog2(DEPTH)-1:0] free_idx
);
  localparam int IW = $clog2(DEPTH);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == key)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/victim_cache_wb.sv
// Fully associative victim cache; probe answers 1 cycle later, dirty displacement stalls in EVICT until wb_ack.
// Probes beat inserts; VICTIM_CACHE_PERF_EN builds saturating hit/miss counters.
module victim_cache_wb import victim_cache_pkg::*; #(
  parameter int LINE_W = VC_LINE_W,
  parameter int TAG_W  = VC_TAG_W,
  parameter int DEPTH  = VC_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  victim_cache_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);

  vc_state_e         state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [DEPTH-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];
  logic              rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_dirty_q, rsp_dirty_d;
  logic [LINE_W-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [LINE_W-1:0] wb_data_q, wb_data_d;
  logic [TAG_W-1:0]  key;
  logic              m_hit, m_free;
  logic [IW-1:0]     m_hit_idx, m_free_idx, ins_idx;

  // At most one operation is accepted per cycle, so one comparator serves both.
  assign key = bus.lookup_req ? bus.lookup_tag : bus.insert_tag;

  victim_cache_match #(.TAG_W(TAG_W), .DEPTH(DEPTH)) u_match (
    .valid      (valid_q),
    .tags       (tag_q),
    .key        (key),
    .hit        (m_hit),
    .hit_idx    (m_hit_idx),
    .free_found (m_free),
    .free_idx   (m_free_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_hit_d   = 1'b0;
    rsp_dirty_d = 1'b0;
    rsp_data_d  = '0;
    wb_tag_d    = wb_tag_q;
    wb_data_d   = wb_data_q;
    ins_idx     = '0;
    case (state_q)
      IDLE: begin
        if (bus.lookup_req) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = m_hit;
          if (m_hit) begin
            rsp_data_d         = data_q[m_hit_idx];
            rsp_dirty_d        = dirty_q[m_hit_idx];
            valid_d[m_hit_idx] = 1'b0;
          end
        end else if (bus.insert_req) begin
          if (m_hit) begin
            ins_idx          = m_hit_idx;
            dirty_d[ins_idx] = dirty_q[ins_idx] | bus.insert_dirty;
          end else if (m_free) begin
            ins_idx          = m_free_idx;
            dirty_d[ins_idx] = bus.insert_dirty;
          end else begin
            ins_idx          = rr_q;
            rr_d             = rr_q + IW'(1);
            dirty_d[ins_idx] = bus.insert_dirty;
            if (dirty_q[rr_q]) begin
              wb_tag_d  = tag_q[rr_q];
              wb_data_d = data_q[rr_q];
              state_d   = EVICT;
            end
          end
          valid_d[ins_idx] = 1'b1;
          tag_d[ins_idx]   = bus.insert_tag;
          data_d[ins_idx]  = bus.insert_data;
        end
      end
      EVICT: begin
        if (bus.wb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_dirty_q <= 1'b0;
      rsp_data_q  <= '0;
      wb_tag_q    <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_dirty_q <= rsp_dirty_d;
      rsp_data_q  <= rsp_data_d;
      wb_tag_q    <= wb_tag_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Line storage carries no reset; valid_q gates every use of it.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.lookup_ready = (state_q == IDLE);
  assign bus.insert_ready = (state_q == IDLE) & ~bus.lookup_req;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_hit      = rsp_hit_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_dirty    = rsp_dirty_q;
  assign bus.wb_req       = (state_q == EVICT);
  assign bus.wb_tag       = wb_tag_q;
  assign bus.wb_data      = wb_data_q;

`ifdef VICTIM_CACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rsp_valid_q && rsp_hit_q && (hit_cnt_q != 32'hFFFF_FFFF))
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (rsp_valid_q && !rsp_hit_q && (miss_cnt_q != 32'hFFFF_FFFF))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.perf_hit_cnt  = hit_cnt_q;
  assign bus.perf_miss_cnt = miss_cnt_q;
`else
  assign bus.perf_hit_cnt  = 32'd0;
  assign bus.perf_miss_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_victim_cache_wb.sv
// Directed bench for victim_cache_wb: probe, insert, replacement, write-back stall and reset.
module tb_victim_cache_wb;
  import victim_cache_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  victim_cache_if #(.LINE_W(VC_LINE_W), .TAG_W(VC_TAG_W)) vc_if ();

  victim_cache_wb #(.LINE_W(VC_LINE_W), .TAG_W(VC_TAG_W), .DEPTH(VC_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ldata(input logic [25:0] t);
    logic [31:0] w;
    w = 32'hD000_0000 | {6'd0, t};
    return {w, ~w, w, 32'h1234_5678};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    vc_if.lookup_req   = 1'b0;
    vc_if.lookup_tag   = '0;
    vc_if.insert_req   = 1'b0;
    vc_if.insert_tag   = '0;
    vc_if.insert_data  = '0;
    vc_if.insert_dirty = 1'b0;
    vc_if.wb_ack       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic probe(input string nm, input logic [25:0] t, input logic exp_hit,
                       input logic [127:0] exp_data, input logic exp_dirty);
    vc_if.lookup_req = 1'b1;
    vc_if.lookup_tag = t;
    tick();
    vc_if.lookup_req = 1'b0;
    chk({nm, ".vld"},   {127'd0, vc_if.rsp_valid}, 128'd1);
    chk({nm, ".hit"},   {127'd0, vc_if.rsp_hit},   {127'd0, exp_hit});
    chk({nm, ".data"},  vc_if.rsp_data,            exp_data);
    chk({nm, ".dirty"}, {127'd0, vc_if.rsp_dirty}, {127'd0, exp_dirty});
  endtask

  task automatic insert(input logic [25:0] t, input logic [127:0] d, input logic dty);
    vc_if.insert_req   = 1'b1;
    vc_if.insert_tag   = t;
    vc_if.insert_data  = d;
    vc_if.insert_dirty = dty;
    #1;
    chk($sformatf("ins%0h.rdy", t), {127'd0, vc_if.insert_ready}, 128'd1);
    tick();
    vc_if.insert_req = 1'b0;
  endtask

  vc_entry_t exp_wb;
  logic [31:0] exp_miss;

  initial begin
    total = 0;
    bad   = 0;
    do_reset();

    // reset state
    rst = 1'b0;
    #1;
    chk("rst.rsp_vld", {127'd0, vc_if.rsp_valid},   128'd0);
    chk("rst.rsp_dat", vc_if.rsp_data,              128'd0);
    chk("rst.wb_req",  {127'd0, vc_if.wb_req},      128'd0);
    chk("rst.wb_tag",  {102'd0, vc_if.wb_tag},      128'd0);
    chk("rst.lk_rdy",  {127'd0, vc_if.lookup_ready}, 128'd1);
    chk("rst.perf_h",  {96'd0, vc_if.perf_hit_cnt}, 128'd0);
    tick();
    rst = 1'b1;
    tick();

    // miss on empty cache; counter lags rsp_valid by a cycle
    probe("p5", 26'h5, 1'b0, 128'd0, 1'b0);
    tick();
    chk("p5.vld_drop", {127'd0, vc_if.rsp_valid}, 128'd0);
`ifdef VICTIM_CACHE_PERF_EN
    exp_miss = 32'd1;
`else
    exp_miss = 32'd0;
`endif
    chk("perf_miss", {96'd0, vc_if.perf_miss_cnt}, {96'd0, exp_miss});

    // fill, hit, swap-invalidate
    for (int i = 1; i <= 4; i++) insert(26'(i), ldata(26'(i)), 1'b0);
    probe("p3a", 26'h3, 1'b1, ldata(26'h3), 1'b0);
    probe("p3b", 26'h3, 1'b0, 128'd0, 1'b0);

    // clean round-robin replacement: 9 -> entry0, B -> entry1
    do_reset();
    for (int i = 1; i <= 4; i++) insert(26'(i), ldata(26'(i)), 1'b0);
    insert(26'h9, ldata(26'h9), 1'b0);
    chk("ins9.wb_req", {127'd0, vc_if.wb_req}, 128'd0);
    insert(26'hB, ldata(26'hB), 1'b0);
    chk("insB.wb_req", {127'd0, vc_if.wb_req}, 128'd0);
    probe("p1", 26'h1, 1'b0, 128'd0, 1'b0);
    probe("p2", 26'h2, 1'b0, 128'd0, 1'b0);
    probe("p9", 26'h9, 1'b1, ldata(26'h9), 1'b0);
    probe("pB", 26'hB, 1'b1, ldata(26'hB), 1'b0);
    // same-tag overwrite merges dirty
    insert(26'h4, 128'hCAFE, 1'b1);
    probe("p4", 26'h4, 1'b1, 128'hCAFE, 1'b1);

    // dirty displacement and held write-back
    do_reset();
    insert(26'h1, ldata(26'h1), 1'b1);
    for (int i = 2; i <= 4; i++) insert(26'(i), ldata(26'(i)), 1'b0);
    exp_wb = '{valid: 1'b1, dirty: 1'b1, tag: 26'h1, data: ldata(26'h1)};
    insert(26'hA, ldata(26'hA), 1'b0);
    chk("ev.wb_req", {127'd0, vc_if.wb_req},       128'd1);
    chk("ev.wb_tag", {102'd0, vc_if.wb_tag},       {102'd0, exp_wb.tag});
    chk("ev.wb_dat", vc_if.wb_data,                exp_wb.data);
    chk("ev.in_rdy", {127'd0, vc_if.insert_ready}, 128'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("ev.hold%0d.req", c), {127'd0, vc_if.wb_req},       128'd1);
      chk($sformatf("ev.hold%0d.rdy", c), {127'd0, vc_if.lookup_ready}, 128'd0);
      chk($sformatf("ev.hold%0d.tag", c), {102'd0, vc_if.wb_tag},       {102'd0, exp_wb.tag});
    end
    vc_if.wb_ack = 1'b1;
    tick();
    vc_if.wb_ack = 1'b0;
    chk("ev.ack.req", {127'd0, vc_if.wb_req},       128'd0);
    chk("ev.ack.rdy", {127'd0, vc_if.lookup_ready}, 128'd1);
    probe("pA", 26'hA, 1'b1, ldata(26'hA), 1'b0);

    // probe and insert in the same cycle: probe wins, insert lands next cycle
    vc_if.lookup_req   = 1'b1;
    vc_if.lookup_tag   = 26'h2;
    vc_if.insert_req   = 1'b1;
    vc_if.insert_tag   = 26'h7;
    vc_if.insert_data  = ldata(26'h7);
    vc_if.insert_dirty = 1'b0;
    #1;
    chk("pri.in_rdy0", {127'd0, vc_if.insert_ready}, 128'd0);
    tick();
    vc_if.lookup_req = 1'b0;
    chk("pri.rsp_vld", {127'd0, vc_if.rsp_valid}, 128'd1);
    chk("pri.rsp_hit", {127'd0, vc_if.rsp_hit},   128'd1);
    chk("pri.rsp_dat", vc_if.rsp_data,            ldata(26'h2));
    #1;
    chk("pri.in_rdy1", {127'd0, vc_if.insert_ready}, 128'd1);
    tick();
    vc_if.insert_req = 1'b0;
    probe("p7", 26'h7, 1'b1, ldata(26'h7), 1'b0);

    // reset while a write-back is pending
    do_reset();
    insert(26'h1, ldata(26'h1), 1'b1);
    for (int i = 2; i <= 4; i++) insert(26'(i), ldata(26'(i)), 1'b0);
    insert(26'h5, ldata(26'h5), 1'b0);
    chk("rev.wb_req", {127'd0, vc_if.wb_req}, 128'd1);
    rst = 1'b0;
    #1;
    chk("rev.wb_req0", {127'd0, vc_if.wb_req},       128'd0);
    chk("rev.wb_tag0", {102'd0, vc_if.wb_tag},       128'd0);
    chk("rev.lk_rdy",  {127'd0, vc_if.lookup_ready}, 128'd1);
    tick();
    rst = 1'b1;
    tick();
    probe("rp2", 26'h2, 1'b0, 128'd0, 1'b0);
    probe("rp5", 26'h5, 1'b0, 128'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
